// File: rtl/wb_dac_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wb_dac_pkg
// Brief  : Shared FSM state type, framing constants and code packing helper
//          for the DAC sequencer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package wb_dac_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_LOAD    = 3'd2,
        S_START   = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5
    } state_t;

    localparam logic [4:0]  C_D12_PAD = 5'b0_0000;
    localparam int unsigned C_WORD_W  = 16;

    // DAC expects the code MSB-aligned in the 16-bit payload.
    function automatic logic [15:0] pack_code(input logic [15:0] code, input int unsigned dw);
        return code << (C_WORD_W - dw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_dac_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wb_dac_sequencer_if
// Brief  : Start/busy handshake and payload towards the I2C4BYTES core.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface wb_dac_sequencer_if;
    logic        i2c_start;
    logic [1:0]  i2c_line;
    logic [15:0] i2c_data12;
    logic [15:0] i2c_data34;
    logic        i2c_busy;

    modport master (output i2c_start, i2c_line, i2c_data12, i2c_data34, input i2c_busy);
    modport slave  (input i2c_start, i2c_line, i2c_data12, i2c_data34, output i2c_busy);
endinterface
`default_nettype wire

// File: rtl/dac_ramp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : dac_ramp
// Brief  : Rate-limited +/-1 LSB stepping of the HV code toward min(target, limit).
// Rev    : 1.0
// ---------------------------------------------------------------------------
module dac_ramp #(
    parameter int DW  = 12,
    parameter int RDW = 24
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [DW-1:0]  target_i,
    input  logic [DW-1:0]  limit_i,
    input  logic [RDW-1:0] div_i,
    input  logic           hv_en_i,
    output logic [DW-1:0]  hv_current_o,
    output logic           at_target_o
);

    logic [DW-1:0]  w_eff;
    logic           w_tick;
    logic [RDW-1:0] div_q;
    logic [DW-1:0]  cur_q;
    logic           at_q;

    assign w_eff  = (target_i < limit_i) ? target_i : limit_i;
    // >= rather than == so a divider shortened mid-count still wraps promptly.
    assign w_tick = (div_i != '0) && (div_q >= div_i - 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            cur_q <= '0;
            at_q  <= 1'b0;
        end else begin
            at_q <= (cur_q == w_eff);
            if (!hv_en_i) begin
                div_q <= '0;
                cur_q <= '0;
            end else if (w_tick) begin
                div_q <= '0;
                if (cur_q < w_eff) begin
                    cur_q <= cur_q + 1'b1;
                end else if (cur_q > w_eff) begin
                    cur_q <= cur_q - 1'b1;
                end
            end else if (div_i != '0) begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign hv_current_o = cur_q;
    assign at_target_o  = at_q;

endmodule
`default_nettype wire

// File: rtl/wb_dac_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wb_dac_sequencer
// Brief  : Holds per-channel DAC codes, ramps the HV channel and sweeps enabled
//          channels over the I2C core with a timed start/busy handshake.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module wb_dac_sequencer
    import wb_dac_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int DW     = 12,
    parameter int RDW    = 24,
    parameter int TO_CYC = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NCH*DW-1:0]     cfg_target_i,
    input  logic [DW-1:0]         cfg_limit_i,
    input  logic [RDW-1:0]        cfg_ramp_div_i,
    input  logic                  cfg_hv_en_i,
    input  logic [NCH-1:0]        cfg_chan_en_i,
    input  logic [NCH*8-1:0]      cfg_dev_addr_i,
    input  logic [NCH*2-1:0]      cfg_line_i,
    input  logic [2:0]            cfg_eeprom_i,
    input  logic [RDW-1:0]        cfg_refresh_i,
    wb_dac_sequencer_if.master    i2c,
    output logic [DW-1:0]         hv_current_o,
    output logic                  hv_at_target_o,
    output logic                  err_timeout_o,
    output logic [15:0]           sweep_count_o
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = $clog2(NCH + 1);
    localparam int TW = $clog2(TO_CYC + 1);

    state_t         state_q;
    logic [PW-1:0]  ptr_q;
    logic [IW-1:0]  k_q;
    logic [RDW-1:0] refresh_q;
    logic [TW-1:0]  phase_q;
    logic           attempted_q;
    logic           err_q;
    logic           start_q;
    logic [15:0]    sweep_q;
    logic [15:0]    d12_q;
    logic [15:0]    d34_q;
    logic [1:0]     line_q;

    logic [7:0]     w_addr [NCH];
    logic [1:0]     w_line [NCH];
    logic [DW-1:0]  w_tgt  [NCH];
    logic [DW-1:0]  w_hv;
    logic [DW-1:0]  w_code;
    logic           w_at;
    logic           w_found;
    logic           w_timeout;
    logic [IW-1:0]  w_next;
    logic [PW-1:0]  w_ptr_next;

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign w_addr[g] = cfg_dev_addr_i[g*8 +: 8];
        assign w_line[g] = cfg_line_i[g*2 +: 2];
        assign w_tgt[g]  = cfg_target_i[g*DW +: DW];
    end

    dac_ramp #(
        .DW  (DW),
        .RDW (RDW)
    ) u_ramp (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .target_i     (w_tgt[0]),
        .limit_i      (cfg_limit_i),
        .div_i        (cfg_ramp_div_i),
        .hv_en_i      (cfg_hv_en_i),
        .hv_current_o (w_hv),
        .at_target_o  (w_at)
    );

    // Lowest enabled channel at or above the sweep pointer.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && cfg_chan_en_i[i] && (PW'(i) >= ptr_q)) begin
                w_found = 1'b1;
                w_next  = IW'(i);
            end
        end
    end

    assign w_code     = (k_q == '0) ? w_hv : w_tgt[k_q];
    assign w_timeout  = (phase_q == TW'(TO_CYC - 1));
    assign w_ptr_next = PW'(k_q) + PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            k_q         <= '0;
            refresh_q   <= '0;
            phase_q     <= '0;
            attempted_q <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            sweep_q     <= '0;
            d12_q       <= '0;
            d34_q       <= '0;
            line_q      <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (refresh_q >= cfg_refresh_i) begin
                        refresh_q <= '0;
                        ptr_q     <= '0;
                        state_q   <= S_SELECT;
                    end else begin
                        refresh_q <= refresh_q + 1'b1;
                    end
                end
                S_SELECT: begin
                    if (w_found) begin
                        k_q     <= w_next;
                        state_q <= S_LOAD;
                    end else begin
                        if (attempted_q) begin
                            sweep_q <= sweep_q + 1'b1;
                        end
                        attempted_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    line_q      <= w_line[k_q];
                    d12_q       <= {w_addr[k_q], cfg_eeprom_i, C_D12_PAD};
                    d34_q       <= pack_code(16'(w_code), DW);
                    attempted_q <= 1'b1;
                    phase_q     <= '0;
                    state_q     <= S_START;
                end
                S_START: begin
                    if (!i2c.i2c_busy) begin
                        start_q <= 1'b1;
                        phase_q <= '0;
                        state_q <= S_WAIT_HI;
                    end else if (w_timeout) begin
                        err_q   <= 1'b1;
                        ptr_q   <= w_ptr_next;
                        state_q <= S_SELECT;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (i2c.i2c_busy) begin
                        phase_q <= '0;
                        state_q <= S_WAIT_LO;
                    end else if (w_timeout) begin
                        err_q   <= 1'b1;
                        ptr_q   <= w_ptr_next;
                        state_q <= S_SELECT;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!i2c.i2c_busy) begin
                        ptr_q   <= w_ptr_next;
                        state_q <= S_SELECT;
                    end else if (w_timeout) begin
                        err_q   <= 1'b1;
                        ptr_q   <= w_ptr_next;
                        state_q <= S_SELECT;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign i2c.i2c_start  = start_q;
    assign i2c.i2c_line   = line_q;
    assign i2c.i2c_data12 = d12_q;
    assign i2c.i2c_data34 = d34_q;

    assign hv_current_o   = w_hv;
    assign hv_at_target_o = w_at;
    assign err_timeout_o  = err_q;
    assign sweep_count_o  = sweep_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_dac_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_wb_dac_sequencer
// Brief  : Directed self-checking bench for the DAC sequencer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_wb_dac_sequencer;
    import wb_dac_pkg::*;

    localparam int NCH    = 4;
    localparam int DW     = 12;
    localparam int RDW    = 24;
    localparam int TO_CYC = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DW-1:0] cfg_target;
    logic [DW-1:0]     cfg_limit;
    logic [RDW-1:0]    cfg_ramp_div;
    logic              cfg_hv_en;
    logic [NCH-1:0]    cfg_chan_en;
    logic [NCH*8-1:0]  cfg_dev_addr;
    logic [NCH*2-1:0]  cfg_line;
    logic [2:0]        cfg_eeprom;
    logic [RDW-1:0]    cfg_refresh;
    logic [DW-1:0]     hv_current;
    logic              hv_at_target;
    logic              err_timeout;
    logic [15:0]       sweep_count;

    wb_dac_sequencer_if u_if ();

    wb_dac_sequencer #(
        .NCH    (NCH),
        .DW     (DW),
        .RDW    (RDW),
        .TO_CYC (TO_CYC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_target_i   (cfg_target),
        .cfg_limit_i    (cfg_limit),
        .cfg_ramp_div_i (cfg_ramp_div),
        .cfg_hv_en_i    (cfg_hv_en),
        .cfg_chan_en_i  (cfg_chan_en),
        .cfg_dev_addr_i (cfg_dev_addr),
        .cfg_line_i     (cfg_line),
        .cfg_eeprom_i   (cfg_eeprom),
        .cfg_refresh_i  (cfg_refresh),
        .i2c            (u_if),
        .hv_current_o   (hv_current),
        .hv_at_target_o (hv_at_target),
        .err_timeout_o  (err_timeout),
        .sweep_count_o  (sweep_count)
    );

    always #5 clk = ~clk;

    // I2C core model: busy for 20 cycles after each start pulse.
    logic resp_en  = 1'b0;
    logic busy     = 1'b0;
    int   busy_cnt = 0;
    assign u_if.i2c_busy = busy;

    always @(negedge clk) begin
        if (!resp_en) begin
            busy     = 1'b0;
            busy_cnt = 0;
        end else if (u_if.i2c_start) begin
            busy     = 1'b1;
            busy_cnt = 20;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            busy     = (busy_cnt != 0);
        end
    end

    logic [15:0] mon_d12  [$];
    logic [15:0] mon_d34  [$];
    logic [1:0]  mon_line [$];

    always @(negedge clk) begin
        if (u_if.i2c_start) begin
            mon_d12.push_back(u_if.i2c_data12);
            mon_d34.push_back(u_if.i2c_data34);
            mon_line.push_back(u_if.i2c_line);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic mon_clear();
        mon_d12.delete();
        mon_d34.delete();
        mon_line.delete();
    endtask

    logic [15:0] exp_d12  [3];
    logic [15:0] exp_d34  [3];
    logic [1:0]  exp_line [3];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_target   = {12'hABC, 12'h777, 12'd2100, 12'd2500};
        cfg_limit    = 12'd4000;
        cfg_ramp_div = 24'd10;
        cfg_hv_en    = 1'b1;
        cfg_chan_en  = 4'b0000;
        cfg_dev_addr = {8'h5A, 8'h99, 8'hC2, 8'h30};
        cfg_line     = {2'd1, 2'd3, 2'd2, 2'd0};
        cfg_eeprom   = 3'd3;
        cfg_refresh  = '0;

        // Reset state, observed while reset is held
        step(2);
        chk("rst_hv", 32'(hv_current), 0);
        chk("rst_at", 32'(hv_at_target), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_sweep", 32'(sweep_count), 0);
        chk("rst_start", 32'(u_if.i2c_start), 0);
        rst = 1'b0;

        // HV ramp: 1 LSB per 10 clocks up to 2500
        step(9);
        chk("ramp_pre_tick", 32'(hv_current), 0);
        step(1);
        chk("ramp_first_tick", 32'(hv_current), 1);
        step(24990);
        chk("ramp_reach", 32'(hv_current), 2500);
        chk("ramp_at_lag", 32'(hv_at_target), 0);
        step(1);
        chk("ramp_at", 32'(hv_at_target), 1);
        step(50);
        chk("ramp_hold", 32'(hv_current), 2500);

        // Limit clamp and lowered limit
        cfg_target   = {12'hABC, 12'h777, 12'd2100, 12'd4000};
        cfg_limit    = 12'd1000;
        cfg_ramp_div = 24'd2;
        do_reset();
        step(1999);
        chk("clamp_999", 32'(hv_current), 999);
        step(1);
        chk("clamp_1000", 32'(hv_current), 1000);
        step(100);
        chk("clamp_hold", 32'(hv_current), 1000);
        chk("clamp_at", 32'(hv_at_target), 1);
        cfg_limit = 12'd900;
        step(1);
        chk("lower_no_jump", 32'(hv_current), 1000);
        step(1);
        chk("lower_first", 32'(hv_current), 999);
        step(198);
        chk("lower_900", 32'(hv_current), 900);
        step(20);
        chk("lower_hold", 32'(hv_current), 900);
        chk("lower_at", 32'(hv_at_target), 1);

        // HV disable, then channel 0 payload carries a zero code
        cfg_limit    = 12'd4000;
        cfg_ramp_div = 24'd1;
        do_reset();
        step(1500);
        chk("hvdis_1500", 32'(hv_current), 1500);
        cfg_hv_en = 1'b0;
        step(1);
        chk("hvdis_zero", 32'(hv_current), 0);
        mon_clear();
        resp_en     = 1'b1;
        cfg_chan_en = 4'b0001;
        for (int i = 0; i < 200 && mon_d34.size() == 0; i++) step(1);
        chk("hvdis_start_seen", 32'(mon_d34.size() != 0), 1);
        if (mon_d34.size() != 0) begin
            chk("hvdis_d34", 32'(mon_d34[0]), 32'h0000);
            chk("hvdis_d12", 32'(mon_d12[0]), 32'h3060);
        end

        // Sweep over channels 0, 1, 3
        resp_en     = 1'b0;
        cfg_chan_en = 4'b1011;
        cfg_refresh = 24'd1000;
        rst = 1'b1;
        step(2);
        mon_clear();
        resp_en = 1'b1;
        rst     = 1'b0;
        step(1300);
        exp_d12[0] = 16'h3060; exp_d34[0] = 16'h0000; exp_line[0] = 2'd0;
        exp_d12[1] = 16'hC260; exp_d34[1] = 16'h8340; exp_line[1] = 2'd2;
        exp_d12[2] = 16'h5A60; exp_d34[2] = 16'hABC0; exp_line[2] = 2'd1;
        chk("sweep_n_start", 32'(mon_d12.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < mon_d12.size()) begin
                chk($sformatf("sweep_d12_%0d", i), 32'(mon_d12[i]), 32'(exp_d12[i]));
                chk($sformatf("sweep_d34_%0d", i), 32'(mon_d34[i]), 32'(exp_d34[i]));
                chk($sformatf("sweep_line_%0d", i), 32'(mon_line[i]), 32'(exp_line[i]));
            end
        end
        chk("sweep_count", 32'(sweep_count), 1);
        chk("sweep_no_err", 32'(err_timeout), 0);

        // Timeout in WAIT_HI with a silent core
        resp_en     = 1'b0;
        cfg_chan_en = 4'b0011;
        cfg_refresh = '0;
        do_reset();
        for (int i = 0; i < 50 && !u_if.i2c_start; i++) step(1);
        chk("to_first_start", 32'(u_if.i2c_start), 1);
        step(199);
        chk("to_not_yet", 32'(err_timeout), 0);
        step(1);
        chk("to_flag", 32'(err_timeout), 1);
        step(2);
        chk("to_gap", 32'(u_if.i2c_start), 0);
        step(1);
        chk("to_next_start", 32'(u_if.i2c_start), 1);
        chk("to_next_d12", 32'(u_if.i2c_data12), 32'hC260);
        chk("to_next_line", 32'(u_if.i2c_line), 2);
        step(500);
        chk("to_sticky", 32'(err_timeout), 1);
        rst = 1'b1;
        step(1);
        chk("to_rst_clear", 32'(err_timeout), 0);

        // Reset while waiting for busy to fall
        cfg_target   = {12'hABC, 12'h777, 12'd2100, 12'd100};
        cfg_hv_en    = 1'b1;
        cfg_ramp_div = 24'd1;
        cfg_chan_en  = 4'b0001;
        resp_en      = 1'b1;
        do_reset();
        for (int i = 0; i < 500 && !(sweep_count != 0 && busy && dut.state_q == S_WAIT_LO); i++) step(1);
        chk("mid_in_wait_lo", 32'(dut.state_q), 32'(S_WAIT_LO));
        chk("mid_sweep_pre", 32'(sweep_count != 0), 1);
        rst = 1'b1;
        step(1);
        chk("mid_start", 32'(u_if.i2c_start), 0);
        chk("mid_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("mid_sweep", 32'(sweep_count), 0);
        chk("mid_hv", 32'(hv_current), 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
